// File: rtl/voice_mix_sequencer_if.sv
// Voice mixer sequencer bus: frame trigger, voice bank port,
// shared mixer port and mixed-sample output.
interface voice_mix_sequencer_if #(
    parameter int NVOICES = 8,
    parameter int W       = 18
);
    localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

    logic          sample_tick;
    logic [IW-1:0] voice_idx;
    logic [W-1:0]  voice_sample;
    logic [W-1:0]  mix_a;
    logic [W-1:0]  mix_b;
    logic [W-1:0]  mix_z;
    logic [W-1:0]  out_sample;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    modport master (
        output sample_tick, voice_sample, mix_z,
        input  voice_idx, mix_a, mix_b, out_sample,
        input  out_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, voice_sample, mix_z,
        output voice_idx, mix_a, mix_b, out_sample,
        output out_valid, busy, overrun
    );
endinterface

// File: rtl/voice_mix_sequencer.sv
// Time-multiplexes one two-input mixer to fold NVOICES
// voice samples into a single output sample per frame.
module voice_mix_sequencer #(
    parameter int NVOICES = 8,
    parameter int W       = 18,
    parameter int MIX_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    voice_mix_sequencer_if.slave  bus
);
    localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam int CW = (MIX_LAT > 0) ? $clog2(MIX_LAT + 1) : 1;
    localparam logic [W-1:0] SILENCE = W'(1) << (W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  mix_a_q, mix_a_d;
    logic [W-1:0]  mix_b_q, mix_b_d;
    logic [W-1:0]  out_q, out_d;
    logic          ovld_q, ovld_d;
    logic          busy_q, busy_d;
    logic          ovr_q, ovr_d;

    logic last_voice;
    logic wait_end;

    assign last_voice = (idx_q == IW'(NVOICES - 1));
    assign wait_end   = (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: one slot per voice, then a single DONE cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.sample_tick) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_WAIT;
            S_WAIT: begin
                if (wait_end) state_d = last_voice ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath/output next values for the current state
    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mix_a_d = mix_a_q;
        mix_b_d = mix_b_q;
        out_d   = out_q;
        ovld_d  = 1'b0;
        busy_d  = ovld_q ? 1'b0 : busy_q;
        ovr_d   = ovr_q | (bus.sample_tick & (state_q != S_IDLE));
        unique case (state_q)
            S_IDLE: begin
                if (bus.sample_tick) begin
                    acc_d  = SILENCE;
                    idx_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_LOAD: begin
                mix_a_d = acc_q;
                mix_b_d = bus.voice_sample;
                cnt_d   = CW'(MIX_LAT);
            end
            S_WAIT: begin
                if (wait_end) begin
                    acc_d = bus.mix_z;
                    if (!last_voice) idx_d = idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                out_d  = acc_q;
                ovld_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= SILENCE;
            mix_a_q <= SILENCE;
            mix_b_q <= SILENCE;
            out_q   <= SILENCE;
            ovld_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mix_a_q <= mix_a_d;
            mix_b_q <= mix_b_d;
            out_q   <= out_d;
            ovld_q  <= ovld_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.voice_idx  = idx_q;
    assign bus.mix_a      = mix_a_q;
    assign bus.mix_b      = mix_b_q;
    assign bus.out_sample = out_q;
    assign bus.out_valid  = ovld_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Bench for voice_mix_sequencer: two voices, behavioural
// mixer and 1-cycle ROM bank, checked against a frame fold model.
module tb_voice_mix_sequencer;
    localparam int NV = 2;
    localparam logic [17:0] SIL = 18'h20000;

    logic clk;
    logic rst_n;

    voice_mix_sequencer_if #(.NVOICES(NV), .W(18)) bus();

    voice_mix_sequencer #(
        .NVOICES(NV),
        .W      (18),
        .MIX_LAT(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [17:0] rom [NV];
    logic [17:0] rom_q;
    logic [17:0] mz1, mz;

    int nchk;
    int npass;
    bit exp_ovr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] mix(logic [17:0] a, logic [17:0] b);
        longint t;
        t = 2 * longint'(a) + 2 * longint'(b)
            - ((longint'(a) * longint'(b)) >>> 17)
            - (longint'(1) << 18);
        return t[17:0];
    endfunction

    function automatic logic [17:0] fold(logic [17:0] v[$]);
        logic [17:0] acc;
        acc = SIL;
        foreach (v[i]) acc = mix(acc, v[i]);
        return acc;
    endfunction

    // Voice bank: registered read, one cycle latency
    always_ff @(posedge clk) rom_q <= rom[bus.voice_idx];

    // Mixer: Z valid two edges after the A/B capture edge
    always_ff @(posedge clk) begin
        mz1 <= mix(bus.mix_a, bus.mix_b);
        mz  <= mz1;
    end

    assign bus.voice_sample = rom_q;
    assign bus.mix_z        = mz;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic frame(input logic [17:0] v0, input logic [17:0] v1,
                         input int ov_at, input bit chain, input bit ticked);
        logic [17:0] q[$];
        int lat;
        q = '{v0, v1};
        rom[0] = v0;
        rom[1] = v1;
        if (!ticked) begin
            @(negedge clk);
            bus.sample_tick = 1'b1;
        end
        @(negedge clk);
        bus.sample_tick = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            if (lat == 3) begin
                check("v0_idx", 32'(bus.voice_idx), 32'd0);
                check("v0_a", 32'(bus.mix_a), 32'(SIL));
                check("v0_b", 32'(bus.mix_b), 32'(v0));
                check("busy_mid", 32'(bus.busy), 32'd1);
            end
            if (lat == 8) begin
                check("v1_idx", 32'(bus.voice_idx), 32'd1);
                check("v1_a", 32'(bus.mix_a), 32'(mix(SIL, v0)));
                check("v1_b", 32'(bus.mix_b), 32'(v1));
            end
            bus.sample_tick = (lat == ov_at);
            @(negedge clk);
            lat++;
        end
        bus.sample_tick = 1'b0;
        if (ov_at >= 0) exp_ovr = 1'b1;
        check("latency", 32'(lat), 32'd11);
        check("out_sample", 32'(bus.out_sample), 32'(fold(q)));
        check("busy_at_valid", 32'(bus.busy), 32'd1);
        check("overrun", 32'(bus.overrun), 32'(exp_ovr));
        if (chain) begin
            bus.sample_tick = 1'b1;
        end else begin
            @(negedge clk);
            check("valid_pulse", 32'(bus.out_valid), 32'd0);
            check("busy_end", 32'(bus.busy), 32'd0);
            check("hold_sample", 32'(bus.out_sample), 32'(fold(q)));
        end
    endtask

    initial begin
        bit seen;
        logic [17:0] r0, r1;
        nchk = 0;
        npass = 0;
        exp_ovr = 1'b0;
        rst_n = 1'b0;
        bus.sample_tick = 1'b0;
        rom[0] = SIL;
        rom[1] = SIL;

        // reset state, no tick
        repeat (3) @(negedge clk);
        check("rst_out", 32'(bus.out_sample), 32'(SIL));
        check("rst_a", 32'(bus.mix_a), 32'(SIL));
        check("rst_b", 32'(bus.mix_b), 32'(SIL));
        check("rst_idx", 32'(bus.voice_idx), 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("idle_novalid", 32'(seen), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_ovr", 32'(bus.overrun), 32'd0);

        // directed frames
        frame(SIL, SIL, -1, 1'b0, 1'b0);
        frame(18'h30000, SIL, -1, 1'b0, 1'b0);
        frame(18'h30000, 18'h30000, -1, 1'b1, 1'b0);
        check("law_38000", 32'(bus.out_sample), 32'h38000);
        frame(18'h30000, SIL, -1, 1'b0, 1'b1);

        // randomized frames
        for (int r = 0; r < 8; r++) begin
            r0 = 18'($urandom);
            r1 = 18'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            frame(r0, r1, -1, 1'b0, 1'b0);
        end

        // overrun: extra tick mid-frame, then again in DONE
        frame(18'h30000, 18'h30000, 3, 1'b0, 1'b0);
        frame(18'($urandom), 18'($urandom), 10, 1'b0, 1'b0);
        frame(18'h25000, 18'h1F000, -1, 1'b0, 1'b0);

        // reset during WAIT of voice 1
        rom[0] = 18'h30000;
        rom[1] = 18'h30000;
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_ovr = 1'b0;
        check("mrst_out", 32'(bus.out_sample), 32'(SIL));
        check("mrst_a", 32'(bus.mix_a), 32'(SIL));
        check("mrst_b", 32'(bus.mix_b), 32'(SIL));
        check("mrst_idx", 32'(bus.voice_idx), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_ovr", 32'(bus.overrun), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("mrst_novalid", 32'(seen), 32'd0);
        frame(18'h30000, 18'h30000, -1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
